// File: rtl/pc_sequencer_if.sv
// Decode/control <-> next-PC sequencer bus.
// The master modport is the control side that raises requests; the slave
// modport is the sequencer that owns the program counter and EPC.
interface pc_sequencer_if;
    logic        stall_i;
    logic        halt_i;
    logic        branch_i;
    logic [31:0] branch_tgt;
    logic        jump_i;
    logic [31:0] jump_tgt;
    logic        jr_i;
    logic [31:0] jr_tgt;
    logic        eret_i;
    logic        exc_i;
    logic        irq_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] epc_o;
    logic        kernel_o;
    logic        flush_o;
    logic        halted_o;

    modport master (
        output stall_i, halt_i, branch_i, branch_tgt, jump_i, jump_tgt,
               jr_i, jr_tgt, eret_i, exc_i, irq_i,
        input  pc_o, pc_plus4_o, epc_o, kernel_o, flush_o, halted_o
    );

    modport slave (
        input  stall_i, halt_i, branch_i, branch_tgt, jump_i, jump_tgt,
               jr_i, jr_tgt, eret_i, exc_i, irq_i,
        output pc_o, pc_plus4_o, epc_o, kernel_o, flush_o, halted_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC and the exception PC (EPC).
// Chooses between halt, exception, interrupt, stall, eret, jr, jump, branch
// and sequential sources in that priority order. Any non-sequential update
// moves the FSM into REDIRECT, which drives flush_o for the following cycle.
// HALT freezes everything until reset.
// Optional build macro: MISALIGN_TRAP_EN -- a selected next PC with nonzero
// low bits traps to EXC_VECTOR with the offending address saved in EPC.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] seq_pc;
    logic [31:0] sel_pc;
    logic        sel_redirect;

    // Address the control-flow requests (eret/jr/jump/branch/sequential) pick.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        seq_pc       = pc_q + 32'd4;
        sel_pc       = seq_pc;
        sel_redirect = 1'b1;
        if (bus.eret_i) begin
            sel_pc = epc_q;
        end else if (bus.jr_i) begin
            sel_pc = bus.jr_tgt;
        end else if (bus.jump_i) begin
            sel_pc = bus.jump_tgt;
        end else if (bus.branch_i) begin
            sel_pc = bus.branch_tgt;
        end else begin
            sel_redirect = 1'b0;
        end
    end

    // Next-state, next-PC and next-EPC decision.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        case (state_q)
            ST_HALT: begin
                // Frozen; only reset leaves this state.
            end
            default: begin
                if (bus.halt_i) begin
                    state_d = ST_HALT;
                end else if (bus.exc_i) begin
                    pc_d    = EXC_VECTOR;
                    epc_d   = pc_q;
                    state_d = ST_REDIRECT;
                end else if (bus.irq_i && !pc_q[31]) begin
                    // A stalled instruction has not advanced, so it is the one to resume.
                    pc_d    = IRQ_VECTOR;
                    epc_d   = bus.stall_i ? pc_q : sel_pc;
                    state_d = ST_REDIRECT;
                end else if (bus.stall_i) begin
                    state_d = ST_RUN;
`ifdef MISALIGN_TRAP_EN
                end else if (sel_pc[1:0] != 2'b00) begin
                    pc_d    = EXC_VECTOR;
                    epc_d   = sel_pc;
                    state_d = ST_REDIRECT;
`endif
                end else begin
                    pc_d    = sel_pc;
                    state_d = sel_redirect ? ST_REDIRECT : ST_RUN;
                end
            end
        endcase
    end

    // State, PC and EPC registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            epc_q   <= 32'h0000_0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = pc_q + 32'd4;
    assign bus.epc_o      = epc_q;
    assign bus.kernel_o   = pc_q[31];
    assign bus.flush_o    = (state_q == ST_REDIRECT);
    assign bus.halted_o   = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, hand-written corner
// sequences (async reset mid-redirect, PC wrap, misaligned target) and a
// randomized run compared against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] IRQ_V = 32'h8000_0004;
    localparam logic [31:0] EXC_V = 32'h8000_0008;

    // Control bit positions for the vector table.
    localparam int C_S = 0;  // stall
    localparam int C_H = 1;  // halt
    localparam int C_B = 2;  // branch
    localparam int C_J = 3;  // jump
    localparam int C_R = 4;  // jr
    localparam int C_E = 5;  // eret
    localparam int C_X = 6;  // exception
    localparam int C_I = 7;  // irq

    typedef struct {
        logic        stall, halt, branch, jump, jr, eret, exc, irq;
        logic [31:0] btgt, jtgt, rtgt;
    } in_t;

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        flush;
        logic        halted;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [31:0] m_pc, m_epc;
    logic        m_flush, m_halted;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic in_t from_ctrl(input logic [7:0] c, input logic [31:0] t);
        in_t r;
        r.stall = c[C_S]; r.halt = c[C_H]; r.branch = c[C_B]; r.jump = c[C_J];
        r.jr = c[C_R]; r.eret = c[C_E]; r.exc = c[C_X]; r.irq = c[C_I];
        r.btgt = t; r.jtgt = t; r.rtgt = t;
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0] c, input logic [31:0] t, input logic [31:0] pc,
                                input logic [31:0] epc, input logic fl, input logic hl);
        vec_t v;
        v.ctrl = c; v.tgt = t; v.pc = pc; v.epc = epc; v.flush = fl; v.halted = hl;
        return v;
    endfunction

    task automatic drive(input in_t s);
        bus.stall_i = s.stall; bus.halt_i = s.halt; bus.branch_i = s.branch;
        bus.jump_i = s.jump; bus.jr_i = s.jr; bus.eret_i = s.eret;
        bus.exc_i = s.exc; bus.irq_i = s.irq;
        bus.branch_tgt = s.btgt; bus.jump_tgt = s.jtgt; bus.jr_tgt = s.rtgt;
    endtask

    // Behavioural reference: the address the ordinary control-flow requests ask for.
    function automatic logic [31:0] wanted_addr(input in_t s);
        if (s.eret)   return m_epc;
        if (s.jr)     return s.rtgt;
        if (s.jump)   return s.jtgt;
        if (s.branch) return s.btgt;
        return m_pc + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_flush = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_step(input in_t s);
        logic [31:0] t;
        if (m_halted) begin
            m_flush = 1'b0;
            return;
        end
        t = wanted_addr(s);
        if (s.halt) begin
            m_halted = 1'b1;
            m_flush  = 1'b0;
        end else if (s.exc) begin
            m_epc = m_pc; m_pc = EXC_V; m_flush = 1'b1;
        end else if (s.irq && (m_pc < 32'h8000_0000)) begin
            m_epc = s.stall ? m_pc : t; m_pc = IRQ_V; m_flush = 1'b1;
        end else if (s.stall) begin
            m_flush = 1'b0;
        end else begin
`ifdef MISALIGN_TRAP_EN
            if (t % 4 != 0) begin
                m_epc = t; m_pc = EXC_V; m_flush = 1'b1;
            end else begin
                m_pc = t; m_flush = s.eret | s.jr | s.jump | s.branch;
            end
`else
            m_pc = t; m_flush = s.eret | s.jr | s.jump | s.branch;
`endif
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".pc"}, bus.pc_o, m_pc);
        check({tag, ".epc"}, bus.epc_o, m_epc);
        check({tag, ".flush"}, {31'b0, bus.flush_o}, {31'b0, m_flush});
        check({tag, ".halted"}, {31'b0, bus.halted_o}, {31'b0, m_halted});
        check({tag, ".plus4"}, bus.pc_plus4_o, m_pc + 32'd4);
        check({tag, ".kernel"}, {31'b0, bus.kernel_o}, {31'b0, m_pc >= 32'h8000_0000});
    endtask

    task automatic step(input in_t s);
        drive(s);
        model_step(s);
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, check reset values, release after an edge.
    task automatic do_reset(input string tag);
        drive(from_ctrl(8'h00, 32'h0));
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_model(tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    vec_t vecs[24];

    initial begin
        in_t s;
        checks = 0;
        failures = 0;
        clk = 1'b0;
        reset = 1'b0;
        drive(from_ctrl(8'h00, 32'h0));
        model_reset();

        vecs[0]  = mk(8'h00, 32'h0,   32'h4,         32'h0,   1'b0, 1'b0);
        vecs[1]  = mk(8'h00, 32'h0,   32'h8,         32'h0,   1'b0, 1'b0);
        vecs[2]  = mk(8'h00, 32'h0,   32'hC,         32'h0,   1'b0, 1'b0);
        vecs[3]  = mk(8'h00, 32'h0,   32'h10,        32'h0,   1'b0, 1'b0);
        vecs[4]  = mk(8'h04, 32'h40,  32'h40,        32'h0,   1'b1, 1'b0);
        vecs[5]  = mk(8'h00, 32'h0,   32'h44,        32'h0,   1'b0, 1'b0);
        vecs[6]  = mk(8'h08, 32'h20,  32'h20,        32'h0,   1'b1, 1'b0);
        vecs[7]  = mk(8'h01, 32'h0,   32'h20,        32'h0,   1'b0, 1'b0);
        vecs[8]  = mk(8'h01, 32'h0,   32'h20,        32'h0,   1'b0, 1'b0);
        vecs[9]  = mk(8'h01, 32'h0,   32'h20,        32'h0,   1'b0, 1'b0);
        vecs[10] = mk(8'h81, 32'h0,   32'h8000_0004, 32'h20,  1'b1, 1'b0);
        vecs[11] = mk(8'h00, 32'h0,   32'h8000_0008, 32'h20,  1'b0, 1'b0);
        vecs[12] = mk(8'h80, 32'h0,   32'h8000_000C, 32'h20,  1'b0, 1'b0);
        vecs[13] = mk(8'h80, 32'h0,   32'h8000_0010, 32'h20,  1'b0, 1'b0);
        vecs[14] = mk(8'h80, 32'h0,   32'h8000_0014, 32'h20,  1'b0, 1'b0);
        vecs[15] = mk(8'h20, 32'h0,   32'h20,        32'h20,  1'b1, 1'b0);
        vecs[16] = mk(8'h10, 32'h30,  32'h30,        32'h20,  1'b1, 1'b0);
        vecs[17] = mk(8'h48, 32'h100, 32'h8000_0008, 32'h30,  1'b1, 1'b0);
        vecs[18] = mk(8'h20, 32'h0,   32'h30,        32'h30,  1'b1, 1'b0);
        vecs[19] = mk(8'h84, 32'h200, 32'h8000_0004, 32'h200, 1'b1, 1'b0);
        vecs[20] = mk(8'h20, 32'h0,   32'h200,       32'h200, 1'b1, 1'b0);
        vecs[21] = mk(8'h08, 32'h50,  32'h50,        32'h200, 1'b1, 1'b0);
        vecs[22] = mk(8'h02, 32'h0,   32'h50,        32'h200, 1'b0, 1'b1);
        vecs[23] = mk(8'hE8, 32'h60,  32'h50,        32'h200, 1'b0, 1'b1);

        // Values while reset is held.
        #12;
        check("rst.pc", bus.pc_o, 32'h0);
        check("rst.epc", bus.epc_o, 32'h0);
        check("rst.flush", {31'b0, bus.flush_o}, 32'h0);
        check("rst.halted", {31'b0, bus.halted_o}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 24; i++) begin
            drive(from_ctrl(vecs[i].ctrl, vecs[i].tgt));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.pc", i), bus.pc_o, vecs[i].pc);
            check($sformatf("vec%0d.epc", i), bus.epc_o, vecs[i].epc);
            check($sformatf("vec%0d.flush", i), {31'b0, bus.flush_o}, {31'b0, vecs[i].flush});
            check($sformatf("vec%0d.halted", i), {31'b0, bus.halted_o}, {31'b0, vecs[i].halted});
            check($sformatf("vec%0d.plus4", i), bus.pc_plus4_o, vecs[i].pc + 32'd4);
            check($sformatf("vec%0d.kernel", i), {31'b0, bus.kernel_o}, {31'b0, vecs[i].pc[31]});
        end

        // Reset releases HALT.
        do_reset("halt_rst");

        // Reset asserted while flush_o is high clears it without a clock edge.
        step(from_ctrl(8'h04, 32'h80));
        compare_model("midredir.pre");
        drive(from_ctrl(8'h00, 32'h0));
        #2;
        reset = 1'b0;
        #1;
        check("midredir.flush", {31'b0, bus.flush_o}, 32'h0);
        check("midredir.pc", bus.pc_o, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Sequential wrap from the top of the address space.
        step(from_ctrl(8'h08, 32'hFFFF_FFFC));
        check("wrap.pc", bus.pc_o, 32'hFFFF_FFFC);
        check("wrap.plus4", bus.pc_plus4_o, 32'h0);
        check("wrap.kernel", {31'b0, bus.kernel_o}, 32'h1);
        step(from_ctrl(8'h00, 32'h0));
        check("wrap.next_pc", bus.pc_o, 32'h0);
        check("wrap.next_flush", {31'b0, bus.flush_o}, 32'h0);

        // Misaligned register target.
        step(from_ctrl(8'h10, 32'h102));
`ifdef MISALIGN_TRAP_EN
        check("misalign.pc", bus.pc_o, EXC_V);
        check("misalign.epc", bus.epc_o, 32'h102);
`else
        check("misalign.pc", bus.pc_o, 32'h102);
        check("misalign.epc", bus.epc_o, 32'h0);
`endif
        check("misalign.flush", {31'b0, bus.flush_o}, 32'h1);

        // Randomized run against the behavioural model.
        do_reset("rand_rst");
        for (int n = 0; n < 600; n++) begin
            s.stall  = ($urandom_range(0, 3) == 0);
            s.halt   = ($urandom_range(0, 63) == 0);
            s.branch = ($urandom_range(0, 3) == 0);
            s.jump   = ($urandom_range(0, 7) == 0);
            s.jr     = ($urandom_range(0, 7) == 0);
            s.eret   = ($urandom_range(0, 7) == 0);
            s.exc    = ($urandom_range(0, 15) == 0);
            s.irq    = ($urandom_range(0, 3) == 0);
            s.btgt   = $urandom & 32'hFFFF_FFFC;
            s.jtgt   = $urandom & 32'hFFFF_FFFC;
            s.rtgt   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) s.jtgt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) s.rtgt[1:0] = 2'($urandom_range(1, 3));
            step(s);
            compare_model($sformatf("rand%0d", n));
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                do_reset($sformatf("rand_rst%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
